// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master types.
//   spi_state_e    - transfer FSM states (IDLE, LEAD, XFER, TRAIL, DONE)
//   spi_mode_t     - latched SPI mode {cpol, cpha}
//   sample_on_lead - 1 when miso is sampled on the leading sck edge
//   shift_on_lead  - 1 when mosi advances on the leading sck edge
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // cpha=0: sample on leading edge, shift on trailing; cpha=1: the reverse.
  function automatic logic sample_on_lead(input spi_mode_t mode);
    return ~mode.cpha;
  endfunction

  function automatic logic shift_on_lead(input spi_mode_t mode);
    return mode.cpha;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter and sck edge-strobe generator.
//   clk, rst       - system clock, async active-high reset
//   run            - count half periods (LEAD/XFER/TRAIL); clears when low
//   edges_en       - allow sck edges (LEAD/XFER)
//   div            - half period is div+1 clk cycles
//   tick_c         - last cycle of the current half period
//   lead_c/trail_c - this tick produces a leading / trailing sck edge
//   edges_done_c   - all 2*DATA_W sck edges have been produced
module spi_clk_div #(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             edges_en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c,
  output logic             lead_c,
  output logic             trail_c,
  output logic             edges_done_c
);

  localparam int unsigned NUM_EDGES = 2 * DATA_W;
  localparam int unsigned EDGE_W    = $clog2(NUM_EDGES + 1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              edge_c;

  // Edges alternate leading/trailing; an even edge count means the next is leading.
  always_comb begin
    tick_c       = run && (cnt_q == div);
    edges_done_c = (edge_q == EDGE_W'(NUM_EDGES));
    edge_c       = tick_c && edges_en && !edges_done_c;
    lead_c       = edge_c && !edge_q[0];
    trail_c      = edge_c && edge_q[0];
    cnt_d        = cnt_q;
    edge_d       = edge_q;
    if (!run) begin
      cnt_d  = '0;
      edge_d = '0;
    end else begin
      cnt_d = tick_c ? '0 : cnt_q + DIV_W'(1);
      if (edge_c) edge_d = edge_q + EDGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      edge_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parameterised SPI master, MSB first, all four modes.
//   clk, rst          - system clock, async active-high reset
//   start             - request a transfer (accepted only when idle)
//   data_in, cs_sel   - word to send, slave index (out of range: no select)
//   cpol, cpha, div   - SPI mode, sck half period = div+1 clk cycles
//   miso              - serial data from slave
//   loopback          - only with SPI_LOOPBACK_EN: use mosi in place of miso
//   sck, mosi, ss_n   - SPI bus outputs
//   busy, done        - transfer in progress, one-cycle completion pulse
//   data_out          - last received word
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned NUM_SS = 4,
  parameter  int unsigned DIV_W  = 8,
  localparam int unsigned CS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  div,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              sck,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic              run_c, edges_en_c;
  logic              tick_c, lead_c, trail_c, edges_done_c;
  logic              shift_evt_c, sample_evt_c;
  logic              miso_int_c;
  logic [NUM_SS-1:0] ss_dec_c;
  spi_mode_t         mode_in_c;

  assign run_c      = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL);
  assign edges_en_c = (state_q == LEAD) || (state_q == XFER);

  spi_clk_div #(
    .DIV_W  (DIV_W),
    .DATA_W (DATA_W)
  ) u_clk_div (
    .clk          (clk),
    .rst          (rst),
    .run          (run_c),
    .edges_en     (edges_en_c),
    .div          (div_q),
    .tick_c       (tick_c),
    .lead_c       (lead_c),
    .trail_c      (trail_c),
    .edges_done_c (edges_done_c)
  );

  // Receive source: internal loopback of mosi when built with the option.
`ifdef SPI_LOOPBACK_EN
  assign miso_int_c = loopback ? mosi_q : miso;
`else
  assign miso_int_c = miso;
`endif

  // Slave-select decode; an out-of-range index matches no bit so all stay high.
  always_comb begin
    ss_dec_c = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      ss_dec_c[i] = (cs_sel != CS_W'(i));
    end
  end

  always_comb begin
    mode_in_c.cpol = cpol;
    mode_in_c.cpha = cpha;
    shift_evt_c    = shift_on_lead(mode_q) ? lead_c : trail_c;
    sample_evt_c   = sample_on_lead(mode_q) ? lead_c : trail_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    div_d      = div_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEAD;
          mode_d  = mode_in_c;
          div_d   = div;
          busy_d  = 1'b1;
          ss_n_d  = ss_dec_c;
          sck_d   = cpol;
          rx_d    = '0;
          // cpha=0 needs the MSB on mosi before the first leading edge;
          // cpha=1 puts it out on that edge instead.
          if (cpha) begin
            mosi_d = 1'b0;
            tx_d   = data_in;
          end else begin
            mosi_d = data_in[DATA_W-1];
            tx_d   = {data_in[DATA_W-2:0], 1'b0};
          end
        end
      end
      LEAD: begin
        if (tick_c) state_d = XFER;
      end
      XFER: begin
        if (tick_c && edges_done_c) state_d = TRAIL;
      end
      TRAIL: begin
        if (tick_c) begin
          state_d    = DONE;
          ss_n_d     = '1;
          done_d     = 1'b1;
          data_out_d = rx_q;
          mosi_d     = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sck_d   = mode_q.cpol;
      end
      default: state_d = IDLE;
    endcase

    if (lead_c || trail_c) sck_d = ~sck_q;
    if (shift_evt_c) begin
      mosi_d = tx_q[DATA_W-1];
      tx_d   = {tx_q[DATA_W-2:0], 1'b0};
    end
    if (sample_evt_c) rx_d = {rx_q[DATA_W-2:0], miso_int_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      div_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per transfer, range 2..32.
REQ-002 SHALL have parameter NUM_SS, default 4: number of slave-select lines, range 1..8.
REQ-003 SHALL have parameter DIV_W, default 8: width of the clock-divider input.
REQ-004 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1: request a transfer; honoured only while busy=0.
REQ-007 SHALL have port data_in, input, DATA_W: word to transmit on mosi.
REQ-008 SHALL have port cs_sel, input, $clog2(NUM_SS) (min 1): index of the slave to select.
REQ-009 SHALL have ports cpol and cpha, input, 1 each: SPI mode.
REQ-010 SHALL have port div, input, DIV_W: SCK half-period H = div+1 clk cycles.
REQ-011 SHALL have port miso, input, 1: serial data from the slave.
REQ-012 SHALL have port sck, output, 1: serial clock.
REQ-013 SHALL have port mosi, output, 1: serial data to the slave.
REQ-014 SHALL have port ss_n, output, NUM_SS: active-low slave selects.
REQ-015 SHALL have port busy, output, 1: transfer in progress.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port data_out, output, DATA_W: last received word.

Function
REQ-018 SHALL latch data_in, cs_sel, cpol, cpha and div on the first clk edge with start=1 and busy=0; later changes on these inputs SHALL NOT affect the current transfer.
REQ-019 SHALL use FSM states IDLE -> LEAD (H cycles) -> XFER (2*DATA_W*H cycles) -> TRAIL (H cycles) -> DONE (1 cycle) -> IDLE.
REQ-020 SHALL raise busy on the cycle after start is accepted and hold it through DONE, giving H*(2*DATA_W+2)+1 busy cycles.
REQ-021 SHALL drive ss_n[cs_sel] low from LEAD through TRAIL and drive all other ss_n bits high; if cs_sel >= NUM_SS, all ss_n bits SHALL stay high and the transfer SHALL still run.
REQ-022 SHALL hold sck at the latched cpol in IDLE, LEAD, TRAIL and DONE, and toggle it every H cycles in XFER, producing exactly DATA_W pulses.
REQ-023 SHALL shift MSB first.
REQ-024 With cpha=0, SHALL present the MSB on mosi on entry to LEAD, sample miso on each leading sck edge, and shift mosi on each trailing edge.
REQ-025 With cpha=1, SHALL shift mosi on each leading edge and sample miso on each trailing edge.
REQ-026 SHALL update data_out with the received word and pulse done for exactly one cycle in DONE; data_out SHALL hold between transfers.
REQ-027 SHALL ignore start while busy=1, with no queuing.
REQ-028 SHALL accept a start asserted during the DONE cycle on the following (IDLE) edge, with no lost cycles beyond that one.
REQ-029 SHALL hold mosi low in IDLE.

Reset
REQ-030 On rst=1 SHALL immediately set state=IDLE, busy=0, done=0, ss_n=all ones, sck=0, mosi=0 and data_out=0, including mid-transfer; no done pulse SHALL be produced for an aborted transfer.
REQ-031 After rst deasserts, SHALL accept start on the first clk edge.

Configuration
REQ-032 SHALL compile in the loopback feature only when macro SPI_LOOPBACK_EN is defined: it adds input port loopback (1 bit) and, while loopback=1, substitutes mosi for miso internally; without the macro the port and mux SHALL be absent and miso SHALL be used directly.

Structure
REQ-033 SHALL take the FSM state enum (IDLE, LEAD, XFER, TRAIL, DONE) and the mode-to-edge encoding from shared package spi_pkg.
REQ-034 SHALL place the half-period counter and edge-strobe generator (leading/trailing strobes) in sub-module spi_clk_div.

Verification
REQ-035 Bench SHALL cover: DATA_W=8, div=0, mode 0, data_in=0xA5, slave returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1; data_out=0x3C; done 19 cycles after busy rises; 8 sck rising edges.
REQ-036 Bench SHALL cover: mode 3, div=3, data_in=0xFF, miso=0x81 -> sck idles high; H=4; busy for 73 cycles; data_out=0x81.
REQ-037 Bench SHALL cover: NUM_SS=4, cs_sel=2 -> ss_n=4'b1011 during the transfer; cs_sel changed to 0 mid-transfer -> ss_n unchanged.
REQ-038 Bench SHALL cover: start pulsed again at XFER midpoint -> ignored; exactly one done pulse; back-to-back start in the DONE cycle -> second transfer begins next cycle.
REQ-039 Bench SHALL cover: rst=1 at the 5th sck edge -> same-cycle ss_n=4'b1111, busy=0, sck=0, data_out=0; no done pulse.
REQ-040 Bench SHALL cover, with SPI_LOOPBACK_EN defined: loopback=1, data_in=0x5A -> data_out=0x5A in all four modes.
